// File: rtl/piso_tx_if.sv
// Handshake and serial bus between a word source and the piso_tx serialiser.
// The master drives the word, load request and bit strobe; the slave returns the serial stream and status.
interface piso_tx_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             done;

  modport master (
    output d, load_valid, shift_en,
    input  load_ready, ser_out, ser_valid, done
  );

  modport slave (
    input  d, load_valid, shift_en,
    output load_ready, ser_out, ser_valid, done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB first, first bit one clock after the load handshake.
// Bits advance only on shift_en strobes; loads are refused outside IDLE, so the source stalls on load_ready.
module piso_tx #(
  parameter int WIDTH = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  piso_tx_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_valid_q, ser_valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    ser_valid_d = ser_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          sr_d        = bus.d;
          cnt_d       = CW'(WIDTH - 1);
          ser_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q != '0) begin
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
          end else begin
            // Clearing the register here is what drives ser_out low in DONE and IDLE.
            sr_d        = '0;
            ser_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        sr_d        = '0;
        cnt_d       = '0;
        ser_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.ser_out    = sr_q[WIDTH-1];
  assign bus.ser_valid  = ser_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx at WIDTH=3: directed scenarios plus randomized words checked against a strobe-counting model.
module tb_piso_tx;

  localparam int W = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  piso_tx_if #(.WIDTH(W)) bus ();

  piso_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b0;
    bus.d          = '0;
    #3;
    checks++;
    if ({bus.load_ready, bus.ser_out, bus.ser_valid, bus.done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async ready/out/valid/done=%b expected 1000",
               {bus.load_ready, bus.ser_out, bus.ser_valid, bus.done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.load_ready, bus.ser_out, bus.ser_valid, bus.done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release ready/out/valid/done=%b expected 1000",
               {bus.load_ready, bus.ser_out, bus.ser_valid, bus.done});
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 3'b101;
    bus.shift_en   = 1'b1;
    bus.d          = w;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (bus.ser_valid !== 1'b1 || bus.ser_out !== w[W-1-i] || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_bit%0d valid=%b out=%b ready=%b expected 1 %b 0",
                 i, bus.ser_valid, bus.ser_out, bus.load_ready, w[W-1-i]);
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.ser_valid !== 1'b0 || bus.ser_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b valid=%b out=%b expected 1 0 0", bus.done, bus.ser_valid, bus.ser_out);
    end
    tick();
    checks++;
    if (bus.load_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready ready=%b done=%b expected 1 0", bus.load_ready, bus.done);
    end
    bus.shift_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    int dones;
    w = 3'b110;
    dones = 0;
    bus.shift_en   = 1'b0;
    bus.d          = w;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int c = 0; c < 4 * W; c++) begin
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.ser_valid !== 1'b1 || bus.ser_out !== w[W-1-(c/4)]) begin
        errors++;
        $display("FAIL stall_cycle%0d valid=%b out=%b expected 1 %b", c, bus.ser_valid, bus.ser_out, w[W-1-(c/4)]);
      end
      bus.shift_en = (c % 4 == 3);
      tick();
    end
    bus.shift_en = 1'b0;
    if (bus.done === 1'b1) dones++;
    tick();
    if (bus.done === 1'b1) dones++;
    checks++;
    if (dones != 1 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_done pulses=%0d ready=%b expected 1 1", dones, bus.load_ready);
    end
  endtask

  task automatic test_ignore_load();
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    w1 = 3'b011;
    w2 = 3'b100;
    bus.shift_en   = 1'b1;
    bus.d          = w1;
    bus.load_valid = 1'b1;
    tick();
    bus.d = w2;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (bus.ser_out !== w1[W-1-i] || bus.ser_valid !== 1'b1 || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_bit%0d out=%b valid=%b ready=%b expected %b 1 0",
                 i, bus.ser_out, bus.ser_valid, bus.load_ready, w1[W-1-i]);
      end
      tick();
    end
    tick();
    checks++;
    if (bus.load_ready !== 1'b1 || bus.ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle ready=%b valid=%b expected 1 0", bus.load_ready, bus.ser_valid);
    end
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (bus.ser_out !== w2[W-1-i] || bus.ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL ignore_second_bit%0d out=%b valid=%b expected %b 1", i, bus.ser_out, bus.ser_valid, w2[W-1-i]);
      end
      tick();
    end
    tick();
    bus.shift_en = 1'b0;
  endtask

  task automatic test_midreset();
    logic [W-1:0] w;
    int dones;
    dones = 0;
    bus.shift_en   = 1'b1;
    bus.d          = 3'b111;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ser_out, bus.ser_valid, bus.done, bus.load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_async out/valid/done/ready=%b expected 0001",
               {bus.ser_out, bus.ser_valid, bus.done, bus.load_ready});
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    w = 3'b010;
    bus.d          = w;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.ser_out !== w[W-1-i] || bus.ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL midreset_bit%0d out=%b valid=%b expected %b 1", i, bus.ser_out, bus.ser_valid, w[W-1-i]);
      end
      tick();
    end
    if (bus.done === 1'b1) dones++;
    tick();
    checks++;
    if (dones != 1 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_done pulses=%0d ready=%b expected 1 1", dones, bus.load_ready);
    end
    bus.shift_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_out;
    logic [9:0] exp_vld;
    logic [9:0] exp_done;
    logic [9:0] got_out;
    logic [9:0] got_vld;
    logic [9:0] got_done;
    exp_out  = 10'b0010010000;
    exp_vld  = 10'b1110011100;
    exp_done = 10'b0001000010;
    bus.shift_en   = 1'b1;
    bus.d          = 3'b001;
    bus.load_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      got_out[9-c]  = bus.ser_out;
      got_vld[9-c]  = bus.ser_valid;
      got_done[9-c] = bus.done;
      if (c == 3) bus.d = 3'b100;
      if (c == 5) bus.load_valid = 1'b0;
    end
    checks++;
    if (got_out !== exp_out || got_vld !== exp_vld || got_done !== exp_done) begin
      errors++;
      $display("FAIL back_to_back out=%b valid=%b done=%b expected %b %b %b",
               got_out, got_vld, got_done, exp_out, exp_vld, exp_done);
    end
    bus.shift_en = 1'b0;
  endtask

  task automatic test_idle_noise();
    bus.load_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.shift_en = c[0];
      bus.d        = W'($urandom);
      tick();
      checks++;
      if ({bus.load_ready, bus.ser_out, bus.ser_valid, bus.done} !== 4'b1000) begin
        errors++;
        $display("FAIL idle_noise_cycle%0d ready/out/valid/done=%b expected 1000",
                 c, {bus.load_ready, bus.ser_out, bus.ser_valid, bus.done});
      end
    end
    bus.shift_en = 1'b0;
  endtask

  task automatic test_release_load();
    logic [W-1:0] w;
    int budget;
    w = W'($urandom);
    bus.shift_en   = 1'b1;
    bus.d          = w;
    bus.load_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    checks++;
    if (bus.ser_valid !== 1'b1 || bus.ser_out !== w[W-1]) begin
      errors++;
      $display("FAIL release_load valid=%b out=%b expected 1 %b", bus.ser_valid, bus.ser_out, w[W-1]);
    end
    budget = 0;
    while (bus.load_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_drain ready=%b expected 1 within 20 cycles", bus.load_ready);
    end
    bus.shift_en = 1'b0;
  endtask

  // Model: after the handshake the visible bit index equals the number of strobes seen so far;
  // the W-th strobe yields a one-cycle done, then the block is idle again.
  task automatic test_random();
    logic [W-1:0] w;
    logic se;
    int k;
    int cycles;
    for (int n = 0; n < 25; n++) begin
      w = W'($urandom);
      bus.d          = w;
      bus.load_valid = 1'b1;
      bus.shift_en   = 1'($urandom);
      tick();
      checks++;
      if (bus.ser_valid !== 1'b1 || bus.ser_out !== w[W-1] || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL rand_w%0d_first valid=%b out=%b ready=%b expected 1 %b 0",
                 n, bus.ser_valid, bus.ser_out, bus.load_ready, w[W-1]);
      end
      k = 0;
      cycles = 0;
      while (k < W && cycles < 200) begin
        se = 1'($urandom_range(0, 2) == 0);
        bus.shift_en   = se;
        bus.load_valid = 1'($urandom);
        bus.d          = W'($urandom);
        tick();
        cycles++;
        if (se) k++;
        checks++;
        if (k < W) begin
          if (bus.ser_valid !== 1'b1 || bus.ser_out !== w[W-1-k] || bus.done !== 1'b0 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rand_w%0d_c%0d valid=%b out=%b done=%b ready=%b expected 1 %b 0 0",
                     n, cycles, bus.ser_valid, bus.ser_out, bus.done, bus.load_ready, w[W-1-k]);
          end
        end else begin
          if (bus.ser_valid !== 1'b0 || bus.ser_out !== 1'b0 || bus.done !== 1'b1 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rand_w%0d_done valid=%b out=%b done=%b ready=%b expected 0 0 1 0",
                     n, bus.ser_valid, bus.ser_out, bus.done, bus.load_ready);
          end
        end
      end
      if (k < W) begin
        errors++;
        $display("FAIL rand_w%0d_timeout strobes=%0d required %0d", n, k, W);
      end
      bus.shift_en   = 1'($urandom);
      bus.load_valid = 1'($urandom);
      tick();
      checks++;
      if (bus.load_ready !== 1'b1 || bus.done !== 1'b0 || bus.ser_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_w%0d_idle ready=%b done=%b valid=%b expected 1 0 0",
                 n, bus.load_ready, bus.done, bus.ser_valid);
      end
    end
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_ignore_load();
    test_midreset();
    test_back_to_back();
    test_idle_noise();
    test_release_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 3, number of data bits per word; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: d  input  WIDTH  parallel word to transmit.
REQ-005 Port: load_valid  input  1  d is valid; request to start a transfer.
REQ-006 Port: load_ready  output  1  block can accept a word; combinational, equals (state == IDLE).
REQ-007 Port: shift_en  input  1  bit-advance strobe (baud/tick), sampled on rising clk.
REQ-008 Port: ser_out  output  1  serial data, MSB first, registered.
REQ-009 Port: ser_valid  output  1  ser_out carries a valid bit, registered.
REQ-010 Port: done  output  1  one-cycle pulse after the last bit completes, registered.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE, and no others are reachable.
REQ-012 In IDLE, a handshake (load_valid & load_ready at a rising edge) SHALL capture d into the shift register, set bit_cnt = WIDTH-1 and move to SHIFT.
REQ-013 On the edge after the handshake, ser_valid SHALL be 1 and ser_out SHALL equal d[WIDTH-1] (zero-cycle gap, latency 1 clk).
REQ-014 In SHIFT, ser_out SHALL always equal the shift register MSB, and ser_valid SHALL stay at 1.
REQ-015 In SHIFT with shift_en=1 and bit_cnt>0, the block SHALL shift left by one (zero fill) and decrement bit_cnt.
REQ-016 In SHIFT with shift_en=1 and bit_cnt==0, the block SHALL move to DONE, clear ser_valid and set ser_out=0.
REQ-017 In SHIFT with shift_en=0, the shift register, bit_cnt, ser_out and ser_valid SHALL hold (arbitrary stall length).
REQ-018 In DONE, done SHALL be 1 for exactly one clock; the FSM SHALL then return to IDLE unconditionally.
REQ-019 load_valid SHALL be ignored in SHIFT and DONE (load_ready=0), with no capture and no state corruption.
REQ-020 shift_en SHALL be ignored in IDLE and DONE.
REQ-021 A word SHALL require exactly WIDTH shift_en strobes in SHIFT; each bit SHALL be held from one strobe to the next.
REQ-022 Back-to-back transfer: minimum spacing between handshakes SHALL be WIDTH strobe cycles + 2 clocks (the DONE cycle plus the IDLE accept cycle).
REQ-023 The d input SHALL only be sampled at the handshake edge; later changes to d SHALL NOT affect the transfer in progress.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, without a clock, force state=IDLE, shift register=0, bit_cnt=0, ser_out=0, ser_valid=0 and done=0; load_ready therefore reads 1.
REQ-025 Reset asserted mid-transfer SHALL abort the word with no done pulse; the first edge after release SHALL accept a new handshake.
REQ-026 A load_valid held high during reset release SHALL be accepted on the first rising edge at which rst_n=1.

Verification
REQ-027 WIDTH=3, reset, then d=3'b101 with load_valid for 1 clk and shift_en held at 1 -> ser_out 1,0,1 on the 3 following clocks with ser_valid=1, done=1 on the 4th clock, load_ready=1 on the 5th.
REQ-028 d=3'b110, shift_en pulsed every 4th clock -> each bit held 4 clocks (1,1,0), ser_valid continuous, single done pulse.
REQ-029 During SHIFT of 3'b011, drive load_valid=1 with d=3'b100 -> load_ready=0, the output stream stays 0,1,1, and 3'b100 is accepted only once load_ready returns to 1.
REQ-030 Assert rst_n=0 between edges after the 2nd bit of 3'b111 -> ser_out, ser_valid and done go to 0 at once, with no done pulse; after release, 3'b010 transmits correctly.
REQ-031 Back-to-back 3'b001 then 3'b100, with load_valid held and shift_en=1 -> stream 0,0,1, gap (DONE, IDLE), then 1,0,0; exactly two done pulses.
REQ-032 Toggle shift_en and load_valid=0 in IDLE for 10 clocks -> all outputs stay at reset values and load_ready stays at 1.
